// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared constants for the video pipeline.
//   - Default 640x480@60 timing (VGA_H_* / VGA_V_*), totals and the pixel
//     divider default for a 50 MHz system clock.
//   - PIXEL_W: coordinate width used by vga_sync_gen and every draw_* stage.
//   - pixel_t: coordinate type, and in_window(): inclusive range test used
//     by the sync decoders.
// -----------------------------------------------------------------------------
package vga_pkg;

  // Coordinate width shared with the draw_* modules.
  localparam int PIXEL_W   = 10;
  localparam int COORD_MAX = 1 << PIXEL_W;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // 640x480@60 horizontal timing, in pixels.
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // 640x480@60 vertical timing, in lines.
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 50 MHz system clock / 2 = 25 MHz pixel rate; sync pulses active-low.
  localparam int VGA_PIX_DIV   = 2;
  localparam bit VGA_SYNC_POL  = 1'b0;

  // True when lo <= val <= hi.
  function automatic logic in_window(input pixel_t val, input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// -----------------------------------------------------------------------------
// vga_pix_div
//   Pixel-rate clock enable. A phase counter runs 0..PIX_DIV-1 and wraps;
//   opixel_tick is registered and is high for one iclk in every PIX_DIV,
//   the first time on the PIX_DIV-th cycle after reset release
//   (every cycle when PIX_DIV = 1).
//
// Ports:
//   iclk        in   system clock
//   ireset      in   synchronous, active-high reset
//   opixel_tick out  registered one-iclk pixel enable
//   otick_next  out  value opixel_tick takes on the next edge, so the parent
//                    can register companion outputs aligned with the tick
// -----------------------------------------------------------------------------
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int PIX_DIV = VGA_PIX_DIV
) (
  input  logic iclk,
  input  logic ireset,
  output logic opixel_tick,
  output logic otick_next
);

  localparam int DIV_W = 2;  // holds 0..3, enough for PIX_DIV up to 4
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  if ((PIX_DIV < 1) || (PIX_DIV > 4)) begin : g_bad_pix_div
    $error("vga_pix_div: PIX_DIV must be in 1..4");
  end

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_tick;

  always_comb begin
    w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    // The tick register samples the phase one cycle late, which puts the
    // first tick exactly PIX_DIV cycles after the first released edge.
    otick_next = (r_div == DIV_LAST);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_tick <= otick_next;
    end
  end

  assign opixel_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Video timing generator. Divides iclk into a pixel enable, runs the
//   horizontal/vertical position counters and produces sync, blanking and
//   frame markers. Every output is a register; sync and video_on are decoded
//   from the next-state counter values so they change on the same edge as
//   opixel_x/opixel_y.
//
// Optional feature (macro VGA_SYNC_FRAME_CNT_EN):
//   adds oframe_cnt[15:0], a wrapping count of oframe_start pulses.
//
// Ports:
//   iclk         in   system clock
//   ireset       in   synchronous, active-high reset (aborts the frame)
//   opixel_x     out  current column, 0..H_TOTAL-1
//   opixel_y     out  current line,   0..V_TOTAL-1
//   ovideo_on    out  high inside the visible H_DISPLAY x V_DISPLAY area
//   ohsync       out  horizontal sync, active level SYNC_POL
//   ovsync       out  vertical sync, active level SYNC_POL
//   opixel_tick  out  one-iclk pixel enable; counters step on the next edge
//   oframe_start out  one-iclk pulse with the tick at position (0,0)
//   oframe_cnt   out  frame counter (only with VGA_SYNC_FRAME_CNT_EN)
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int PIX_DIV   = VGA_PIX_DIV,
  parameter bit SYNC_POL  = VGA_SYNC_POL
) (
  input  logic               iclk,
  input  logic               ireset,
  output logic [PIXEL_W-1:0] opixel_x,
  output logic [PIXEL_W-1:0] opixel_y,
  output logic               ovideo_on,
  output logic               ohsync,
  output logic               ovsync,
  output logic               opixel_tick,
  output logic               oframe_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0]        oframe_cnt
`endif
);

  localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_DISPLAY + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam pixel_t H_LAST = pixel_t'(H_TOTAL - 1);
  localparam pixel_t V_LAST = pixel_t'(V_TOTAL - 1);

  if (H_TOTAL > COORD_MAX) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL exceeds the 10-bit coordinate range");
  end
  if (V_TOTAL > COORD_MAX) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL exceeds the 10-bit coordinate range");
  end

  // ---------------------------------------------------------------------------
  // Pixel enable
  // ---------------------------------------------------------------------------
  logic w_tick;
  logic w_tick_next;

  vga_pix_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_div (
    .iclk        (iclk),
    .ireset      (ireset),
    .opixel_tick (w_tick),
    .otick_next  (w_tick_next)
  );

  // ---------------------------------------------------------------------------
  // Position counters and next-state decode
  // ---------------------------------------------------------------------------
  pixel_t r_h;
  pixel_t r_v;
  pixel_t w_h_next;
  pixel_t w_v_next;
  logic   w_h_wrap;
  logic   w_hs_active;
  logic   w_vs_active;
  logic   w_video_next;
  logic   w_frame_start_next;

  always_comb begin
    w_h_wrap = w_tick && (r_h == H_LAST);

    w_h_next = r_h;
    if (w_tick) begin
      w_h_next = w_h_wrap ? '0 : r_h + pixel_t'(1);
    end

    w_v_next = r_v;
    if (w_h_wrap) begin
      w_v_next = (r_v == V_LAST) ? '0 : r_v + pixel_t'(1);
    end

    // Decoding the next-state position keeps every registered output
    // aligned with the counter registers on the same edge.
    w_hs_active  = in_window(w_h_next, HS_START, HS_END);
    w_vs_active  = in_window(w_v_next, VS_START, VS_END);
    w_video_next = (int'(w_h_next) < H_DISPLAY) && (int'(w_v_next) < V_DISPLAY);

    // The tick register loads w_tick_next on this same edge, so the marker
    // lands in the cycle where the tick is high at position (0,0).
    w_frame_start_next = w_tick_next && (w_h_next == '0) && (w_v_next == '0);
  end

  logic r_hsync;
  logic r_vsync;
  logic r_video_on;
  logic r_frame_start;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_h           <= '0;
      r_v           <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_hsync       <= w_hs_active ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_active ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= w_video_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  assign opixel_x     = r_h;
  assign opixel_y     = r_v;
  assign ohsync       = r_hsync;
  assign ovsync       = r_vsync;
  assign ovideo_on    = r_video_on;
  assign opixel_tick  = w_tick;
  assign oframe_start = r_frame_start;

`ifdef VGA_SYNC_FRAME_CNT_EN
  // ---------------------------------------------------------------------------
  // Frame counter: steps on the edge that closes each oframe_start pulse,
  // wrapping naturally at 16 bits.
  // ---------------------------------------------------------------------------
  logic [15:0] r_frame_cnt;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_frame_cnt <= '0;
    end else if (r_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign oframe_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Three instances share one clock:
//     dut_a : default 640x480 timing, PIX_DIV=2, active-low sync
//     dut_b : reduced 15x8 timing, PIX_DIV=1, active-low sync
//             (hsync x=10..12, vsync y=5..6, visible 8x4)
//     dut_c : same reduced timing, PIX_DIV=3, active-high sync
//   The reduced instances keep whole-frame runs short.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_von, a_hs, a_vs, a_tick, a_fs;
  logic b_von, b_hs, b_vs, b_tick, b_fs;
  logic c_von, c_hs, c_vs, c_tick, c_fs;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] a_cnt, b_cnt, c_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  vga_sync_gen dut_a (
    .iclk (clk), .ireset (rst_a),
    .opixel_x (a_x), .opixel_y (a_y), .ovideo_on (a_von),
    .ohsync (a_hs), .ovsync (a_vs), .opixel_tick (a_tick), .oframe_start (a_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .oframe_cnt (a_cnt)
`endif
  );

  vga_sync_gen #(
    .H_DISPLAY (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_DISPLAY (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .PIX_DIV (1), .SYNC_POL (1'b0)
  ) dut_b (
    .iclk (clk), .ireset (rst_b),
    .opixel_x (b_x), .opixel_y (b_y), .ovideo_on (b_von),
    .ohsync (b_hs), .ovsync (b_vs), .opixel_tick (b_tick), .oframe_start (b_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .oframe_cnt (b_cnt)
`endif
  );

  vga_sync_gen #(
    .H_DISPLAY (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_DISPLAY (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .PIX_DIV (3), .SYNC_POL (1'b1)
  ) dut_c (
    .iclk (clk), .ireset (rst_c),
    .opixel_x (c_x), .opixel_y (c_y), .ovideo_on (c_von),
    .ohsync (c_hs), .ovsync (c_vs), .opixel_tick (c_tick), .oframe_start (c_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .oframe_cnt (c_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge before sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low_cnt, hs_first_x, hs_last_x, von_fall_x, y_bad, fs_cnt;
    int pulse_k[3];
    int np;
    int found;

    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    step(3);

    // ---------------- reset state ----------------
    check("a_rst_x", a_x, 0);
    check("a_rst_y", a_y, 0);
    check("a_rst_tick", a_tick, 0);
    check("a_rst_fs", a_fs, 0);
    check("a_rst_hs", a_hs, 1);
    check("a_rst_vs", a_vs, 1);
    check("a_rst_von", a_von, 0);
    check("c_rst_hs", c_hs, 0);
    check("c_rst_vs", c_vs, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("a_rst_cnt", a_cnt, 0);
`endif

    // ---------------- dut_a: release, first tick, one full line ----------------
    rst_a = 1'b0;
    step(1);  // k=1
    $display("a: k=1 x=%0d tick=%0d von=%0d", a_x, a_tick, a_von);
    check("a_k1_von", a_von, 1);
    check("a_k1_tick", a_tick, 0);
    check("a_k1_x", a_x, 0);
    step(1);  // k=2
    $display("a: k=2 x=%0d tick=%0d fs=%0d", a_x, a_tick, a_fs);
    check("a_k2_tick", a_tick, 1);
    check("a_k2_fs", a_fs, 1);
    check("a_k2_x", a_x, 0);
    step(1);  // k=3
    $display("a: k=3 x=%0d tick=%0d fs=%0d", a_x, a_tick, a_fs);
    check("a_k3_x", a_x, 1);
    check("a_k3_tick", a_tick, 0);
    check("a_k3_fs", a_fs, 0);

    hs_low_cnt = 0; hs_first_x = -1; hs_last_x = -1;
    von_fall_x = -1; y_bad = 0; fs_cnt = 0;
    for (int k = 4; k <= 1600; k++) begin
      step(1);
      if (!a_hs) begin
        hs_low_cnt++;
        if (hs_first_x < 0) hs_first_x = int'(a_x);
        hs_last_x = int'(a_x);
      end
      if (!a_von && von_fall_x < 0) von_fall_x = int'(a_x);
      if (a_y != 10'd0) y_bad++;
      if (a_fs) fs_cnt++;
      if (k == 1600) check("a_x_last", a_x, 799);
    end
    $display("a: line hs_low=%0d first=%0d last=%0d von_fall=%0d", hs_low_cnt, hs_first_x, hs_last_x, von_fall_x);
    check("a_hs_low_clks", hs_low_cnt, 192);
    check("a_hs_first_x", hs_first_x, 656);
    check("a_hs_last_x", hs_last_x, 751);
    check("a_von_fall_x", von_fall_x, 640);
    check("a_y_in_line", y_bad, 0);
    check("a_fs_in_line", fs_cnt, 0);
    step(1);  // k=1601: wrap
    $display("a: k=1601 x=%0d y=%0d", a_x, a_y);
    check("a_wrap_x", a_x, 0);
    check("a_wrap_y", a_y, 1);
    check("a_wrap_von", a_von, 1);
    check("a_wrap_hs", a_hs, 1);

    // ---------------- dut_b: PIX_DIV=1, two frames, per-edge alignment ----------------
    rst_b = 1'b0;
    for (int k = 1; k <= 240; k++) begin
      int n, ex, ey;
      step(1);
      n  = k - 1;
      ex = n % 15;
      ey = (n / 15) % 8;
      check("b_x", b_x, ex);
      check("b_y", b_y, ey);
      check("b_tick", b_tick, 1);
      check("b_hs", b_hs, (ex >= 10 && ex <= 12) ? 0 : 1);
      check("b_vs", b_vs, (ey >= 5 && ey <= 6) ? 0 : 1);
      check("b_von", b_von, (ex < 8 && ey < 4) ? 1 : 0);
      check("b_fs", b_fs, (ex == 0 && ey == 0) ? 1 : 0);
      if (ex == 0) $display("b: k=%0d line start y=%0d vs=%0d fs=%0d", k, b_y, b_vs, b_fs);
    end

    // ---------------- dut_c: PIX_DIV=3, frame spacing, frame count ----------------
    rst_c = 1'b0;
    np = 0;
    for (int k = 1; k <= 730; k++) begin
      step(1);
      if (k == 1) check("c_k1_von", c_von, 1);
      if (k == 2) check("c_k2_tick", c_tick, 0);
      if (k == 3) check("c_k3_tick", c_tick, 1);
      if (k == 4) check("c_k4_x", c_x, 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
      if (k == 2) check("c_cnt_before", c_cnt, 0);
      if (k == 4) check("c_cnt_first", c_cnt, 1);
`endif
      if (c_fs) begin
        if (np < 3) pulse_k[np] = k;
        np++;
      end
    end
    $display("c: frame pulses=%0d at k=%0d,%0d,%0d", np, pulse_k[0], pulse_k[1], pulse_k[2]);
    check("c_pulse_count", np, 3);
    check("c_pulse0_k", pulse_k[0], 3);
    check("c_pulse_gap1", pulse_k[1] - pulse_k[0], 360);
    check("c_pulse_gap2", pulse_k[2] - pulse_k[1], 360);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("c_cnt_3frames", c_cnt, 3);
`endif

    // ---------------- dut_c: reset inside active hsync and vsync ----------------
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      step(1);
      if (c_x == 10'd11 && c_y == 10'd5) found = 1;
    end
    check("c_reach_pos", found, 1);
    $display("c: at x=%0d y=%0d hs=%0d vs=%0d von=%0d", c_x, c_y, c_hs, c_vs, c_von);
    check("c_pre_hs", c_hs, 1);
    check("c_pre_vs", c_vs, 1);
    check("c_pre_von", c_von, 0);
    rst_c = 1'b1;
    step(1);
    $display("c: reset x=%0d y=%0d hs=%0d vs=%0d", c_x, c_y, c_hs, c_vs);
    check("c_mid_x", c_x, 0);
    check("c_mid_y", c_y, 0);
    check("c_mid_hs", c_hs, 0);
    check("c_mid_vs", c_vs, 0);
    check("c_mid_von", c_von, 0);
    check("c_mid_tick", c_tick, 0);
    check("c_mid_fs", c_fs, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("c_mid_cnt", c_cnt, 0);
`endif
    rst_c = 1'b0;
    step(1);
    check("c_re_von", c_von, 1);
    check("c_re_tick", c_tick, 0);
    step(2);
    check("c_re_tick3", c_tick, 1);
    check("c_re_fs", c_fs, 1);
    step(1);
    $display("c: restart x=%0d tick=%0d", c_x, c_tick);
    check("c_re_x", c_x, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
